axi_burst_sram: RTL and testbench

//  Synthesizable AXI4 burst slave over a parametrised on-chip word array. Serves as memory

---
 rtl/axi_burst_sram_if.sv | 42 ++++
 rtl/axi_burst_sram.sv | 202 ++++++++++++++++++++
 tb/tb_axi_burst_sram.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_sram_if.sv
// rtl/axi_burst_sram_if.sv - AXI4 burst bus bundle (AR/R/AW/W/B) for axi_burst_sram
interface axi_burst_sram_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              r_valid, r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              w_valid, w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              w_last;
  logic              b_valid, b_ready;
  logic [1:0]        b_resp;

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    input  w_valid, w_data, w_strb, w_last, b_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last,
    output aw_ready, w_ready, b_valid, b_resp
  );

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    output w_valid, w_data, w_strb, w_last, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last,
    input  aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/axi_burst_sram.sv
// rtl/axi_burst_sram.sv - AXI4 FIXED/INCR/WRAP burst slave over a word array; optional AXI_SRAM_STALL_EN
module axi_burst_sram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000)
) (
  input  logic clock,
  input  logic reset,
  axi_burst_sram_if.slave bus
);
  localparam int LANES = DATA_W / 8;
  localparam int LB    = $clog2(LANES);
  localparam int IW    = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LB);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  typedef enum logic {RIDLE, RDATA} rd_state_t;
  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wr_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    burst_bad = (size > MAX_SIZE) || (burst == 2'b11) ||
                ((burst == WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    word_idx = (addr - BASE_ADDR) >> LB;
  endfunction

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    out_of_range = (addr < BASE_ADDR) || (word_idx(addr) >= ADDR_W'(DEPTH));
  endfunction

  // Malformed bursts hold their start address so the beat count still runs to len+1.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst, input logic bad);
    logic [ADDR_W-1:0] step, mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    if (bad || burst == FIXED) next_addr = addr;
    else if (burst == INCR)    next_addr = addr + step;
    else                       next_addr = (addr & ~mask) | ((addr + step) & mask);
  endfunction

  logic stall;
`ifdef AXI_SRAM_STALL_EN
  logic [7:0] lfsr;
  // Fibonacci LFSR (taps 8,6,5,4) throttling the data channels pseudo-randomly
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------- read channel ----------------
  rd_state_t         rd_state, rd_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len, rd_cnt;
  logic [2:0]        rd_size;
  logic [1:0]        rd_burst, rd_resp;
  logic              rd_bad, ar_ready_i, r_valid_i, ar_hs, r_hs;
  logic [IW-1:0]     rd_idx;

  assign ar_hs   = bus.ar_valid && ar_ready_i;
  assign r_hs    = r_valid_i && bus.r_ready;
  assign rd_idx  = IW'(word_idx(rd_addr));
  assign rd_resp = out_of_range(rd_addr) ? DECERR : (rd_bad ? SLVERR : OKAY);

  // read state register
  always_ff @(posedge clock) begin
    if (reset) rd_state <= RIDLE;
    else       rd_state <= rd_next;
  end

  // read next-state: leave RDATA on the handshake of beat len
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RIDLE: if (ar_hs) rd_next = RDATA;
      RDATA: if (r_hs && rd_cnt == rd_len) rd_next = RIDLE;
      default: rd_next = RIDLE;
    endcase
  end

  // read outputs; data is a combinational array read, zeroed on idle or error beats
  always_comb begin
    ar_ready_i  = (rd_state == RIDLE);
    r_valid_i   = (rd_state == RDATA) && !stall;
    bus.r_last  = (rd_state == RDATA) && (rd_cnt == rd_len);
    bus.r_resp  = (rd_state == RDATA) ? rd_resp : OKAY;
    bus.r_data  = (r_valid_i && rd_resp == OKAY) ? mem[rd_idx] : '0;
  end
  assign bus.ar_ready = ar_ready_i;
  assign bus.r_valid  = r_valid_i;

  // read burst context: latched at accept, advanced per beat
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr <= '0; rd_len <= '0; rd_cnt <= '0; rd_size <= '0; rd_burst <= '0; rd_bad <= 1'b0;
    end else if (ar_hs) begin
      rd_addr  <= bus.ar_addr;
      rd_len   <= bus.ar_len;
      rd_size  <= bus.ar_size;
      rd_burst <= bus.ar_burst;
      rd_bad   <= burst_bad(bus.ar_len, bus.ar_size, bus.ar_burst);
      rd_cnt   <= '0;
    end else if (r_hs) begin
      rd_cnt  <= rd_cnt + 8'd1;
      rd_addr <= next_addr(rd_addr, rd_len, rd_size, rd_burst, rd_bad);
    end
  end

  // ---------------- write channel ----------------
  wr_state_t         wr_state, wr_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_len, wr_cnt;
  logic [2:0]        wr_size;
  logic [1:0]        wr_burst, wr_err, wr_beat_resp;
  logic              wr_bad, aw_ready_i, w_ready_i, b_valid_i, aw_hs, w_hs, wr_beat_ok;
  logic [IW-1:0]     wr_idx;
  logic [LANES-1:0]  lane_en;
  logic [LB:0]       wr_lo, wr_step, wr_hi;

  assign aw_hs        = bus.aw_valid && aw_ready_i;
  assign w_hs         = bus.w_valid && w_ready_i;
  assign wr_idx       = IW'(word_idx(wr_addr));
  assign wr_beat_ok   = !wr_bad && !out_of_range(wr_addr);
  assign wr_beat_resp = out_of_range(wr_addr) ? DECERR :
                        ((wr_bad || (bus.w_last != (wr_cnt == wr_len))) ? SLVERR : OKAY);

  // write state register
  always_ff @(posedge clock) begin
    if (reset) wr_state <= WIDLE;
    else       wr_state <= wr_next;
  end

  // write next-state: the beat count alone ends the data phase
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WIDLE:   if (aw_hs) wr_next = WDATA;
      WDATA:   if (w_hs && wr_cnt == wr_len) wr_next = WRESP;
      WRESP:   if (bus.b_ready) wr_next = WIDLE;
      default: wr_next = WIDLE;
    endcase
  end

  // write outputs
  always_comb begin
    aw_ready_i = (wr_state == WIDLE);
    w_ready_i  = (wr_state == WDATA) && !stall;
    b_valid_i  = (wr_state == WRESP);
  end
  assign bus.aw_ready = aw_ready_i;
  assign bus.w_ready  = w_ready_i;
  assign bus.b_valid  = b_valid_i;
  assign bus.b_resp   = b_valid_i ? wr_err : OKAY;

  // lanes inside the beat window: from the beat address up to the end of its size-aligned slot
  always_comb begin
    wr_lo   = {1'b0, wr_addr[LB-1:0]};
    wr_step = (LB+1)'(1) << wr_size;
    wr_hi   = (wr_lo & ~(wr_step - (LB+1)'(1))) + wr_step;
    lane_en = '0;
    for (int i = 0; i < LANES; i++)
      lane_en[i] = bus.w_strb[i] && ((LB+1)'(i) >= wr_lo) && ((LB+1)'(i) < wr_hi);
  end

  // write burst context; response keeps the worst error seen (DECERR > SLVERR > OKAY)
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr <= '0; wr_len <= '0; wr_cnt <= '0; wr_size <= '0; wr_burst <= '0;
      wr_bad <= 1'b0; wr_err <= OKAY;
    end else if (aw_hs) begin
      wr_addr  <= bus.aw_addr;
      wr_len   <= bus.aw_len;
      wr_size  <= bus.aw_size;
      wr_burst <= bus.aw_burst;
      wr_bad   <= burst_bad(bus.aw_len, bus.aw_size, bus.aw_burst);
      wr_err   <= burst_bad(bus.aw_len, bus.aw_size, bus.aw_burst) ? SLVERR : OKAY;
      wr_cnt   <= '0;
    end else if (w_hs) begin
      wr_cnt  <= wr_cnt + 8'd1;
      wr_addr <= next_addr(wr_addr, wr_len, wr_size, wr_burst, wr_bad);
      if (wr_beat_resp > wr_err) wr_err <= wr_beat_resp;
    end
  end

  // array write port; contents survive reset
  always_ff @(posedge clock) begin
    if (w_hs && wr_beat_ok)
      for (int i = 0; i < LANES; i++)
        if (lane_en[i]) mem[wr_idx][8*i +: 8] <= bus.w_data[8*i +: 8];
  end
endmodule

// File: tb/tb_axi_burst_sram.sv
// tb/tb_axi_burst_sram.sv - scoreboard bench for axi_burst_sram with a byte-level reference model
module tb_axi_burst_sram;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 64;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int NBYTES = DEPTH * 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_burst_sram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axi_burst_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed { logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
  rbeat_t     r_exp[$];
  logic [1:0] b_exp[$];
  logic [7:0] ref_mem [NBYTES];
  int checks = 0;
  int fails  = 0;
  rbeat_t     mon_rb;
  logic [1:0] mon_br;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic bit burst_bad(int len, int size, int burst);
    return size > 3 || burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] beat_addr(logic [31:0] start, int len, int size, int burst, int k);
    longint s, w, b, st;
    s  = longint'(1) << size;
    st = longint'(start);
    if (burst_bad(len, size, burst) || burst == 0) return start;
    if (burst == 1) return 32'(st + k * s);
    w = (len + 1) * s;
    b = (st / w) * w;
    return 32'(b + ((st - b) + k * s) % w);
  endfunction

  function automatic bit out_range(logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 3) >= 32'(DEPTH));
  endfunction

  function automatic logic [63:0] ref_word(logic [31:0] a);
    int w;
    logic [63:0] d;
    w = int'((a - BASE) >> 3);
    for (int i = 0; i < 8; i++) d[8*i +: 8] = ref_mem[w*8 + i];
    return d;
  endfunction

  // monitor: pops the scoreboard whenever the DUT completes an R or B handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.r_valid && bus.r_ready) begin
        if (r_exp.size() == 0) begin
          checks++; fails++;
          $display("FAIL r_unexpected_beat: got resp %b data %h, none expected", bus.r_resp, bus.r_data);
        end else begin
          mon_rb = r_exp.pop_front();
          check("r_beat{data,resp,last}", 72'({bus.r_data, bus.r_resp, bus.r_last}), 72'(mon_rb));
        end
      end else if (!bus.r_valid) begin
        check("r_data_zero_when_idle", 72'(bus.r_data), 72'(0));
      end
      if (bus.b_valid && bus.b_ready) begin
        if (b_exp.size() == 0) begin
          checks++; fails++;
          $display("FAIL b_unexpected: got resp %b, none expected", bus.b_resp);
        end else begin
          mon_br = b_exp.pop_front();
          check("b_resp", 72'(bus.b_resp), 72'(mon_br));
        end
      end
    end
  end

  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock); ok = bus.ar_ready;
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_aw(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock); ok = bus.aw_ready;
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_w(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clock); ok = bus.w_ready;
      @(posedge clock); #1;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int size, input int burst,
                         input bit bp, output int cycles);
    logic [31:0] a;
    bit bad, ok;
    rbeat_t e;
    bad = burst_bad(len, size, burst);
    for (int k = 0; k <= len; k++) begin
      a = beat_addr(addr, len, size, burst, k);
      e.resp = out_range(a) ? 2'b11 : (bad ? 2'b10 : 2'b00);
      e.data = (e.resp == 2'b00) ? ref_word(a) : 64'h0;
      e.last = (k == len);
      r_exp.push_back(e);
    end
    bus.ar_addr = addr; bus.ar_len = 8'(len); bus.ar_size = 3'(size); bus.ar_burst = 2'(burst);
    bus.ar_valid = 1'b1;
    wait_ar(ok);
    bus.ar_valid = 1'b0;
    if (!ok) timeout("ar_handshake");
    cycles = 0;
    while (r_exp.size() > 0 && cycles < 1000) begin
      bus.r_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clock); #1;
      cycles++;
    end
    bus.r_ready = 1'b1;
    if (r_exp.size() > 0) begin
      timeout("r_beats");
      r_exp.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int size, input int burst,
                          input int bad_last, input bit full_strb, input int bhold);
    logic [31:0] a;
    bit bad, ok, last, oor;
    logic [1:0] worst, br;
    logic [63:0] d;
    logic [7:0] s;
    longint lo, hi, sz;
    int n;
    bad   = burst_bad(len, size, burst);
    worst = bad ? 2'b10 : 2'b00;
    bus.aw_addr = addr; bus.aw_len = 8'(len); bus.aw_size = 3'(size); bus.aw_burst = 2'(burst);
    bus.aw_valid = 1'b1;
    wait_aw(ok);
    bus.aw_valid = 1'b0;
    if (!ok) timeout("aw_handshake");
    for (int k = 0; k <= len; k++) begin
      a    = beat_addr(addr, len, size, burst, k);
      d    = {$urandom, $urandom};
      s    = full_strb ? 8'hFF : 8'($urandom);
      last = (k == len) != (k == bad_last);
      oor  = out_range(a);
      br   = oor ? 2'b11 : ((bad || (last != (k == len))) ? 2'b10 : 2'b00);
      if (br > worst) worst = br;
      if (!oor && !bad) begin
        sz = longint'(1) << size;
        lo = longint'(a);
        hi = (lo / sz) * sz + sz;
        for (longint b = lo; b < hi; b++)
          if (s[b % 8]) ref_mem[int'(b - longint'(BASE))] = d[8*(b % 8) +: 8];
      end
      if (!full_strb && $urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
      bus.w_data = d; bus.w_strb = s; bus.w_last = last; bus.w_valid = 1'b1;
      wait_w(ok);
      bus.w_valid = 1'b0;
      if (!ok) timeout("w_handshake");
    end
    b_exp.push_back(worst);
    if (bhold > 0) bus.b_ready = 1'b0;
    @(negedge clock);
    check("b_valid_after_last_beat", 72'(bus.b_valid), 72'(1));
    for (int i = 0; i < bhold; i++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("b_valid_held_while_b_ready_low", 72'(bus.b_valid), 72'(1));
    end
    if (bhold > 0) begin
      @(posedge clock); #1;
      bus.b_ready = 1'b1;
    end
    n = 0;
    while (b_exp.size() > 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    @(posedge clock); #1;
    if (b_exp.size() > 0) begin
      timeout("b_response");
      b_exp.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, len, size, burst;
    bit ok;
    logic [31:0] a;
    bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
    bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0;
    bus.r_ready = 1; bus.b_ready = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ar_ready", 72'(bus.ar_ready), 72'(1));
    check("reset_aw_ready", 72'(bus.aw_ready), 72'(1));
    check("reset_r_valid", 72'(bus.r_valid), 72'(0));
    check("reset_r_last", 72'(bus.r_last), 72'(0));
    check("reset_w_ready", 72'(bus.w_ready), 72'(0));
    check("reset_b_valid", 72'(bus.b_valid), 72'(0));
    check("reset_resps", 72'({bus.r_resp, bus.b_resp}), 72'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    do_write(BASE, DEPTH - 1, 3, 1, -1, 1'b1, 0);

    do_read(BASE, 3, 3, 1, 1'b0, cyc);
    check("incr_read_4_beats_back_to_back", 72'(cyc), 72'(4));

    do_write(BASE + 32'h10, 3, 3, 2, -1, 1'b1, 0);
    do_read(BASE, 3, 3, 1, 1'b0, cyc);

    do_write(BASE + 32'd5, 0, 0, 1, -1, 1'b1, 0);
    do_read(BASE, 0, 3, 1, 1'b0, cyc);

    do_read(BASE + 32'(NBYTES) - 32'd8, 1, 3, 1, 1'b0, cyc);
    do_read(BASE + 32'(NBYTES) - 32'd8, 2, 3, 2, 1'b0, cyc);

    do_write(BASE + 32'd64, 1, 3, 1, 0, 1'b1, 5);
    do_read(BASE + 32'd64, 1, 3, 1, 1'b0, cyc);

    bus.r_ready = 1'b0;
    bus.ar_addr = BASE + 32'd32; bus.ar_len = 8'd3; bus.ar_size = 3'd3; bus.ar_burst = 2'd1;
    bus.ar_valid = 1'b1;
    wait_ar(ok);
    bus.ar_valid = 1'b0;
    if (!ok) timeout("ar_before_reset");
    @(negedge clock);
    check("r_valid_pending_before_reset", 72'(bus.r_valid), 72'(1));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("ar_ready_after_mid_burst_reset", 72'(bus.ar_ready), 72'(1));
    check("r_valid_after_mid_burst_reset", 72'(bus.r_valid), 72'(0));
    bus.r_ready = 1'b1;
    @(posedge clock); #1;
    do_read(BASE + 32'd32, 3, 3, 1, 1'b0, cyc);
    check("reissued_read_cycles", 72'(cyc), 72'(4));

    for (int i = 0; i < 60; i++) begin
      len   = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 7));
      size  = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(0, 3));
      burst = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      a = BASE - 32'd16 + 32'($urandom_range(0, NBYTES + 16));
      if (burst == 2 && size <= 3) a = a & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 1) == 1)
        do_read(a, len, size, burst, 1'b1, cyc);
      else
        do_write(a, len, size, burst,
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len)) : -1,
                 1'b0, int'($urandom_range(0, 2)));
    end
    do_read(BASE, DEPTH - 1, 3, 1, 1'b1, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
